// File: rtl/sha256_funcs_unit.sv
// sha256_funcs_unit
// The six SHA-256 logical functions (Ch, Maj, Sigma0, Sigma1, sigma0,
// sigma1) on 32-bit words, all evaluated in parallel.
//
// Build option:
//   SHA256_FUNCS_REG_EN  defined   -> outputs registered on posedge clk,
//                                     1-cycle latency, synchronous
//                                     active-low reset to zero.
//                        undefined -> purely combinational outputs;
//                                     clk and rst_n are unused.
`timescale 1ns/1ps

module sha256_funcs_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic [31:0] z,
    output logic [31:0] Ch,
    output logic [31:0] Maj,
    output logic [31:0] Sigma0,
    output logic [31:0] Sigma1,
    output logic [31:0] sigma0,
    output logic [31:0] sigma1
);

    logic [31:0] ch_c;
    logic [31:0] maj_c;
    logic [31:0] big_sigma0_c;
    logic [31:0] big_sigma1_c;
    logic [31:0] small_sigma0_c;
    logic [31:0] small_sigma1_c;

    // Pure wiring and XOR/AND/NOT: a rotate is a fixed concatenation of
    // bit slices, and a logical shift right pads the MSBs with zeros.
    always_comb begin
        ch_c           = (x & y) ^ (~x & z);
        maj_c          = (x & y) ^ (x & z) ^ (y & z);
        big_sigma0_c   = {x[1:0],  x[31:2]}  ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
        big_sigma1_c   = {x[5:0],  x[31:6]}  ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
        small_sigma0_c = {x[6:0],  x[31:7]}  ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
        small_sigma1_c = {y[16:0], y[31:17]} ^ {y[18:0], y[31:19]} ^ {10'b0, y[31:10]};
    end

`ifdef SHA256_FUNCS_REG_EN

    // Output register stage: one result per cycle, cleared while rst_n is low.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values; the reset is checked inside the clocked block,
    // which keeps it synchronous to clk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Ch     <= '0;
            Maj    <= '0;
            Sigma0 <= '0;
            Sigma1 <= '0;
            sigma0 <= '0;
            sigma1 <= '0;
        end else begin
            Ch     <= ch_c;
            Maj    <= maj_c;
            Sigma0 <= big_sigma0_c;
            Sigma1 <= big_sigma1_c;
            sigma0 <= small_sigma0_c;
            sigma1 <= small_sigma1_c;
        end
    end

`else

    // Clock and reset are intentionally unused in the combinational build.
    logic unused_ctrl;
    assign unused_ctrl = clk ^ rst_n;

    // Zero-latency outputs: results follow x/y/z in the same cycle.
    always_comb begin
        Ch     = ch_c;
        Maj    = maj_c;
        Sigma0 = big_sigma0_c;
        Sigma1 = big_sigma1_c;
        sigma0 = small_sigma0_c;
        sigma1 = small_sigma1_c;
    end

`endif

endmodule

// File: tb/tb_sha256_funcs_unit.sv
// Self-checking bench for sha256_funcs_unit. Works for both builds: with
// SHA256_FUNCS_REG_EN defined it expects one cycle of latency and a
// synchronous clear to zero; otherwise it expects combinational outputs.
`timescale 1ns/1ps

module tb_sha256_funcs_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] x, y, z;
    logic [31:0] ch, maj, big_sigma0, big_sigma1, small_sigma0, small_sigma1;

    int checks   = 0;
    int failures = 0;

    logic [31:0] obs   [6];
    logic [31:0] exp_v [6];
    string       fn_name [6] = '{"Ch", "Maj", "Sigma0", "Sigma1", "sigma0", "sigma1"};

    sha256_funcs_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .x      (x),
        .y      (y),
        .z      (z),
        .Ch     (ch),
        .Maj    (maj),
        .Sigma0 (big_sigma0),
        .Sigma1 (big_sigma1),
        .sigma0 (small_sigma0),
        .sigma1 (small_sigma1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        obs[0] = ch;
        obs[1] = maj;
        obs[2] = big_sigma0;
        obs[3] = big_sigma1;
        obs[4] = small_sigma0;
        obs[5] = small_sigma1;
    end

    // ---------------- reference model (bit-level definitions) ----------------
    function automatic logic [31:0] m_rotr(input logic [31:0] v, input int n);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[(i + n) % 32];
        return r;
    endfunction

    function automatic logic [31:0] m_shr(input logic [31:0] v, input int n);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = (i + n < 32) ? v[(i + n) % 32] : 1'b0;
        return r;
    endfunction

    function automatic logic [31:0] m_ch(input logic [31:0] a, b, c);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = a[i] ? b[i] : c[i];
        return r;
    endfunction

    function automatic logic [31:0] m_maj(input logic [31:0] a, b, c);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = (int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2;
        return r;
    endfunction

    task automatic compute_model(input logic [31:0] a, b, c);
        exp_v[0] = m_ch(a, b, c);
        exp_v[1] = m_maj(a, b, c);
        exp_v[2] = m_rotr(a, 2)  ^ m_rotr(a, 13) ^ m_rotr(a, 22);
        exp_v[3] = m_rotr(a, 6)  ^ m_rotr(a, 11) ^ m_rotr(a, 25);
        exp_v[4] = m_rotr(a, 7)  ^ m_rotr(a, 18) ^ m_shr(a, 3);
        exp_v[5] = m_rotr(b, 17) ^ m_rotr(b, 19) ^ m_shr(b, 10);
    endtask

    // Drive inputs at the falling edge; sample #1 after the edge that makes
    // the result visible (the next rising edge in the registered build).
    task automatic apply(input logic [31:0] a, b, c);
        @(negedge clk);
        x = a;
        y = b;
        z = c;
`ifdef SHA256_FUNCS_REG_EN
        @(posedge clk);
`endif
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 1'b0;
`ifdef SHA256_FUNCS_REG_EN
        @(negedge clk);
        x = $urandom; y = $urandom; z = $urandom;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (obs[k] !== 32'h0) begin
                failures++;
                $display("FAIL reset_%s: got %08h expected 00000000", fn_name[k], obs[k]);
            end
        end
`else
        // Combinational build: outputs track inputs even while rst_n is low.
        for (int n = 0; n < 3; n++) begin
            logic [31:0] a, b, c;
            a = $urandom; b = $urandom; c = $urandom;
            apply(a, b, c);
            compute_model(a, b, c);
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (obs[k] !== exp_v[k]) begin
                    failures++;
                    $display("FAIL reset_track_%s: got %08h expected %08h", fn_name[k], obs[k], exp_v[k]);
                end
            end
        end
`endif
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        int          fn;
        logic [31:0] want;
    } vec_t;

    vec_t dir_tbl [10] = '{
        '{32'h00000001, 32'h00000000, 32'h00000000, 2, 32'h40080400},
        '{32'h00000001, 32'h00000000, 32'h00000000, 3, 32'h04200080},
        '{32'h00000001, 32'h00000000, 32'h00000000, 4, 32'h02004000},
        '{32'h00000000, 32'h00000001, 32'h00000000, 5, 32'h0000A000},
        '{32'h00000000, 32'h00000400, 32'h00000000, 5, 32'h02800001},
        '{32'h00000008, 32'h00000000, 32'h00000000, 4, 32'h10020001},
        '{32'hFFFFFFFF, 32'h12345678, 32'h9ABCDEF0, 0, 32'h12345678},
        '{32'h00000000, 32'h12345678, 32'h9ABCDEF0, 0, 32'h9ABCDEF0},
        '{32'hFFFFFFFF, 32'h00000000, 32'h0F0F0F0F, 1, 32'h0F0F0F0F},
        '{32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 1, 32'hA5A5A5A5}
    };

    task automatic test_known_vectors;
        rst_n = 1'b1;
`ifdef SHA256_FUNCS_REG_EN
        // First valid result one edge after reset release with x = 1.
        apply(32'h00000001, 32'h0, 32'h0);
        checks++;
        if (big_sigma0 !== 32'h40080400) begin
            failures++;
            $display("FAIL first_after_reset_Sigma0: got %08h expected 40080400", big_sigma0);
        end
`endif
        for (int n = 0; n < 10; n++) begin
            apply(dir_tbl[n].a, dir_tbl[n].b, dir_tbl[n].c);
            checks++;
            if (obs[dir_tbl[n].fn] !== dir_tbl[n].want) begin
                failures++;
                $display("FAIL known_%0d_%s: got %08h expected %08h",
                         n, fn_name[dir_tbl[n].fn], obs[dir_tbl[n].fn], dir_tbl[n].want);
            end
        end
    endtask

    task automatic test_isolation;
        logic [31:0] a, b;
        rst_n = 1'b1;
        a = $urandom;
        b = $urandom;
        compute_model(a, b, 32'h0);
        for (int n = 0; n < 40; n++) begin
            apply(a, b, $urandom);
            for (int k = 2; k < 6; k++) begin
                checks++;
                if (obs[k] !== exp_v[k]) begin
                    failures++;
                    $display("FAIL isolation_z_%s: got %08h expected %08h", fn_name[k], obs[k], exp_v[k]);
                end
            end
        end
    endtask

    // Back-to-back random sets, one per cycle, against the model.
    task automatic test_random;
        rst_n = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            logic [31:0] a, b, c;
            a = $urandom; b = $urandom; c = $urandom;
            apply(a, b, c);
            compute_model(a, b, c);
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (obs[k] !== exp_v[k]) begin
                    failures++;
                    $display("FAIL random_%0d_%s: x=%08h y=%08h z=%08h got %08h expected %08h",
                             n, fn_name[k], a, b, c, obs[k], exp_v[k]);
                end
            end
        end
    endtask

    task automatic test_midstream_reset;
        logic [31:0] a, b, c;
        rst_n = 1'b1;
        apply($urandom | 32'h1, $urandom | 32'h1, $urandom | 32'h1);
        a = $urandom | 32'h1; b = $urandom | 32'h1; c = $urandom | 32'h1;
        @(negedge clk);
        rst_n = 1'b0;
        x = a; y = b; z = c;
`ifdef SHA256_FUNCS_REG_EN
        @(posedge clk);
        #1;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (obs[k] !== 32'h0) begin
                failures++;
                $display("FAIL midstream_reset_%s: got %08h expected 00000000", fn_name[k], obs[k]);
            end
        end
`else
        #1;
        compute_model(a, b, c);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (obs[k] !== exp_v[k]) begin
                failures++;
                $display("FAIL midstream_track_%s: got %08h expected %08h", fn_name[k], obs[k], exp_v[k]);
            end
        end
`endif
        // Recovery: the first set after release must come out correctly.
        @(negedge clk);
        rst_n = 1'b1;
        a = $urandom; b = $urandom; c = $urandom;
        apply(a, b, c);
        compute_model(a, b, c);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (obs[k] !== exp_v[k]) begin
                failures++;
                $display("FAIL post_reset_%s: got %08h expected %08h", fn_name[k], obs[k], exp_v[k]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        x = '0;
        y = '0;
        z = '0;
        test_reset;
        test_known_vectors;
        test_isolation;
        test_random;
        test_midstream_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
